// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// instr_sequencer : instruction address sequencer with return-address stack
// Rev 1.0
// ============================================================================
module instr_sequencer #(
   parameter int                     INS_ADDR_SIZE = 8,
   parameter int                     STACK_DEPTH   = 4,
   parameter logic [INS_ADDR_SIZE-1:0] RESET_ADDR  = '0
) (
   input  logic                               clk,
   input  logic                               reset_enable,
   input  logic                               stall,
   input  logic [2:0]                         op,
   input  logic [INS_ADDR_SIZE-1:0]           adj,
   input  logic [INS_ADDR_SIZE-1:0]           target,
   output logic [INS_ADDR_SIZE-1:0]           out,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
   output logic                               overflow,
   output logic                               underflow
);

   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

   localparam logic [2:0] OP_HOLD     = 3'd0;
   localparam logic [2:0] OP_INC      = 3'd1;
   localparam logic [2:0] OP_REL      = 3'd2;
   localparam logic [2:0] OP_ABS      = 3'd3;
   localparam logic [2:0] OP_CALL_REL = 3'd4;
   localparam logic [2:0] OP_CALL_ABS = 3'd5;
   localparam logic [2:0] OP_RET      = 3'd6;

   logic [INS_ADDR_SIZE-1:0] out_reg       = RESET_ADDR;
   logic [DW-1:0]            depth_reg     = '0;
   logic                     overflow_reg  = 1'b0;
   logic                     underflow_reg = 1'b0;
   logic [INS_ADDR_SIZE-1:0] stack [2**IW];

   logic [INS_ADDR_SIZE-1:0] out_inc;
   logic [DW-1:0]            depth_dec;
   logic [IW-1:0]            push_idx;
   logic [IW-1:0]            pop_idx;
   logic [INS_ADDR_SIZE-1:0] nxt_out;
   logic [DW-1:0]            nxt_depth;
   logic                     push;
   logic                     set_ovf;
   logic                     set_unf;

   assign out_inc   = out_reg + 1'b1;
   assign depth_dec = depth_reg - 1'b1;
   assign push_idx  = depth_reg[IW-1:0];
   assign pop_idx   = depth_dec[IW-1:0];

   always_comb begin
      nxt_out   = out_reg;
      nxt_depth = depth_reg;
      push      = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      case (op)
         OP_INC: nxt_out = out_inc;
         OP_REL: nxt_out = out_reg + adj;
         OP_ABS: nxt_out = target;
         OP_CALL_REL, OP_CALL_ABS: begin
            nxt_out = (op == OP_CALL_REL) ? (out_reg + adj) : target;
            // A full stack still takes the jump; only the push is dropped.
            if (depth_reg == DEPTH_MAX) begin
               set_ovf = 1'b1;
            end else begin
               push      = 1'b1;
               nxt_depth = depth_reg + 1'b1;
            end
         end
         OP_RET: begin
            if (depth_reg == '0) begin
               set_unf = 1'b1;
            end else begin
               nxt_out   = stack[pop_idx];
               nxt_depth = depth_dec;
            end
         end
         default: nxt_out = out_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_enable) begin
         out_reg       <= RESET_ADDR;
         depth_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (!stall) begin
         out_reg       <= nxt_out;
         depth_reg     <= nxt_depth;
         overflow_reg  <= overflow_reg | set_ovf;
         underflow_reg <= underflow_reg | set_unf;
      end
   end

   // Stack contents need no reset: entries at or above depth are never read.
   always_ff @(posedge clk) begin
      if (!reset_enable && !stall && push) begin
         stack[push_idx] <= out_inc;
      end
   end

   assign out       = out_reg;
   assign depth     = depth_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INS_ADDR_SIZE, default 8: width of the instruction address.
REQ-002 SHALL have parameter STACK_DEPTH, default 4: return-address stack entries (≥1).
REQ-003 SHALL have parameter RESET_ADDR, default 0: value loaded into out on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_enable  input  1  reset: synchronous and active-high.
REQ-006 SHALL have port stall  input  1  freezes all state when high.
REQ-007 SHALL have port op  input  3  operation select (see REQ-012).
REQ-008 SHALL have port adj  input  INS_ADDR_SIZE  signed relative offset.
REQ-009 SHALL have port target  input  INS_ADDR_SIZE  absolute destination.
REQ-010 SHALL have port out  output  INS_ADDR_SIZE  current instruction address, registered.
REQ-011 SHALL have ports depth (output, clog2(STACK_DEPTH+1) bits: valid stack entries), overflow (output, 1: sticky) and underflow (output, 1: sticky).

Function
REQ-012 op encoding SHALL be: 0 HOLD; 1 INC (out+1); 2 REL (out+adj); 3 ABS (target); 4 CALL_REL (push out+1, out+adj); 5 CALL_ABS (push out+1, target); 6 RET (out←popped entry); 7 reserved, behaves as HOLD.
REQ-013 Every op SHALL take effect at the first rising edge where it is sampled; the new out is visible one cycle later; no multi-cycle ops.
REQ-014 Address arithmetic SHALL be modulo 2^INS_ADDR_SIZE; adj sign-extended implicitly; no overflow flag for address wrap.
REQ-015 Pushed return address SHALL be out+1 (mod 2^INS_ADDR_SIZE), computed from the pre-update out.
REQ-016 Stack SHALL be LIFO; push writes entry[depth] and increments depth; pop reads entry[depth-1] and decrements depth.
REQ-017 CALL with depth==STACK_DEPTH SHALL still perform the jump, SHALL NOT modify stack contents or depth, and SHALL set overflow.
REQ-018 RET with depth==0 SHALL leave out unchanged, depth at 0, and SHALL set underflow.
REQ-019 overflow and underflow SHALL remain set until reset; they SHALL NOT affect subsequent op execution.
REQ-020 stall high SHALL hold out, depth, stack contents and flags regardless of op.
REQ-021 Priority SHALL be reset_enable > stall > op.
REQ-022 Stack entries above depth SHALL be don't-care; behaviour SHALL not depend on their contents.
REQ-023 Outputs SHALL be driven only from registers (no combinational path from op/adj/target to out).

Reset
REQ-024 On a clock edge with reset_enable high: out←RESET_ADDR, depth←0, overflow←0, underflow←0, regardless of stall and op.
REQ-025 Reset mid-sequence (e.g. during CALL) SHALL discard the operation; no push occurs.
REQ-026 Power-up initial values SHALL equal reset values.

Verification (INS_ADDR_SIZE=8, STACK_DEPTH=4, RESET_ADDR=0)
REQ-027 Reset, then INC ×3 -> out 0,1,2,3 on successive cycles; depth 0; flags 0.
REQ-028 out=0x10, REL adj=-0x20 -> out 0xF0; then REL adj=+0x20 -> out 0x10 (wrap both ways).
REQ-029 out=0x05, CALL_ABS target=0x40 -> out 0x40, depth 1; CALL_REL adj=+2 -> out 0x42, depth 2; RET -> out 0x41; RET -> out 0x06, depth 0.
REQ-030 Five CALL_ABS target=0x80 from out=0 -> fifth leaves depth 4, out 0x80, overflow 1; four RETs return 0x81,0x81,0x81,0x01; fifth RET -> out unchanged, underflow 1.
REQ-031 CALL_ABS target=0x33 with stall=1 for 3 cycles -> out, depth unchanged; stall drops -> out 0x33 next cycle.
REQ-032 reset_enable=1 with stall=1 and op=CALL_ABS, depth 2, overflow 1 -> next cycle out 0, depth 0, both flags 0.
